demux_deser2ch: RTL
===================

Name: demux_deser2ch

Overview:
- Downstream consumer of the 1-bit enabled demultiplexer.
- Takes the two demultiplexed serial streams (a0/a1) plus the same sel/enable strobes that drive the demux, and assembles each channel's bits into parallel words.
- Each completed word is presented on a per-channel valid/ready handshake toward the parallel-side logic.
- Overflow is flagged when a channel's output register is still occupied as its next word completes.

Parameters:
- W, 8, word width in bits per channel (2..32).
- MSB_FIRST, 1, 1 = first received bit lands in bit W-1; 0 = first bit lands in bit 0.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sel  input  1  channel select, same signal driving the demux (0 = a0, 1 = a1).
- enable  input  1  bit strobe, same signal driving the demux; one bit is consumed per cycle with enable=1.
- a0  input  1  demux output channel 0.
- a1  input  1  demux output channel 1.
- sync  input  1  synchronous frame realign; clears both bit counters and partial shift registers.
- d0  output  W  channel 0 word.
- v0  output  1  channel 0 word valid.
- r0  input  1  channel 0 ready.
- d1  output  W  channel 1 word.
- v1  output  1  channel 1 word valid.
- r1  input  1  channel 1 ready.
- ovf0  output  1  sticky overflow, channel 0.
- ovf1  output  1  sticky overflow, channel 1.
- clr_ovf  input  1  synchronous clear of ovf0/ovf1.

Behaviour:
- Reset (async, rst=1):
  - d0, d1 = 0; v0, v1 = 0; ovf0, ovf1 = 0.
  - Shift registers and bit counters = 0.
  - Takes effect immediately, mid-word or mid-handshake; partial words are discarded.
- Bit capture:
  - A cycle with enable=1 and sel=0 shifts a0 into shift register sr0 and increments cnt0.
  - sel=1 does the same for a1 into sr1/cnt1.
  - The other channel's state is untouched.
  - enable=0 means no change.
- Per-channel word state machine (states COLLECT, HOLD):
  - COLLECT: holding register empty (vN=0).
  - HOLD: vN=1, dN stable until the cycle vN&rN=1.
  - Completion: the capture cycle where cnt reaches W-1 and a bit is accepted.
  - On completion, {sr, new bit} (ordered per MSB_FIRST) is the completed word and cnt wraps to 0.
  - If vN=0, or vN=1 and rN=1 in the same cycle: dN <= completed word and vN <= 1 on the next edge (latency: 1 cycle after the last bit's edge). Simultaneous consume and reload gives back-to-back valid with no bubble.
  - If vN=1 and rN=0: completed word is dropped, dN unchanged, ovfN <= 1.
  - vN&rN=1 with no completion: vN <= 0; dN holds its last value.
- sync:
  - Clears cnt0, cnt1, sr0, sr1 on the next edge.
  - Does not affect dN/vN/ovfN.
  - Dominates a capture in the same cycle; that bit is discarded.
- Overflow flags:
  - ovfN is sticky until clr_ovf=1 or reset.
  - If clr_ovf and a new overflow occur in the same cycle, set wins (ovfN=1).
- Channels are fully independent; only one can capture per cycle, since sel is exclusive.
- rN is ignored while vN=0.

Test Plan:
- W=8, MSB_FIRST=1, sel=0, enable=1 for 8 cycles with a0 = 1,0,1,0,0,1,1,0; r0=1:
  - v0=1 on the cycle after the 8th bit with d0=0xA6, held one cycle, then v0=0.
  - v1, d1 and cnt1 stay 0.
- Interleave channels: alternate sel each enabled cycle, ch0 bits form 0x3C and ch1 bits form 0xF0, r0=r1=0:
  - Both valids rise on their respective completion edges and hold; d0=0x3C, d1=0xF0 stable.
- Overflow: with d0=0x3C held and r0=0, send a second ch0 word 0x55:
  - d0 stays 0x3C; ovf0=1 from the completion edge.
  - After clr_ovf pulse, ovf0=0.
- Back-to-back: r0 tied 1, ch0 sends 0x81 then 0x7E contiguously:
  - v0 high for exactly one cycle per word, d0 = 0x81 then 0x7E.
  - ovf0 stays 0.
- Realign: send 5 ch0 bits, pulse sync, then 8 bits forming 0xC3:
  - d0=0xC3 (first 5 bits discarded); no earlier v0.
- Async reset: assert rst between clock edges after 4 bits with v1=1:
  - All outputs 0 immediately.
  - After release, a full 8-bit word completes normally.
- Repeat the first case with MSB_FIRST=0:
  - d0=0x65.

Source files
------------

// File: rtl/demux_deser2ch.sv
// Purpose: deserialises the two demux output streams into per-channel W-bit words.
// Latency: a word is valid one cycle after the edge that captures its last bit.
// Backpressure: a word that completes while the previous one is unconsumed is dropped and flagged sticky in ovfN.
module demux_deser2ch #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sel,
    input  logic         enable,
    input  logic         a0,
    input  logic         a1,
    input  logic         sync,
    output logic [W-1:0] d0,
    output logic         v0,
    input  logic         r0,
    output logic [W-1:0] d1,
    output logic         v1,
    input  logic         r1,
    output logic         ovf0,
    output logic         ovf1,
    input  logic         clr_ovf
);

    localparam int CW = $clog2(W);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    logic [1:0]   bit_in;
    logic [1:0]   rdy;
    logic [W-1:0] dout [2];
    logic [1:0]   vout;
    logic [1:0]   ovf;

    assign bit_in = {a1, a0};
    assign rdy    = {r1, r0};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [W-2:0]  sr;
        logic [CW-1:0] cnt;
        logic          cap;
        logic          done;
        logic [W-1:0]  word;
        state_t        state;
        state_t        state_nxt;
        logic          load;
        logic          ovf_set;
        logic [W-1:0]  d_q;
        logic          ovf_q;

        // sync wins over a capture in the same cycle, so that bit is discarded
        assign cap  = enable && (sel == 1'(ch)) && !sync;
        assign done = cap && (cnt == CW'(W - 1));
        // the shift register holds the W-1 earlier bits; the incoming bit completes the word
        assign word = MSB_FIRST ? {sr, bit_in[ch]} : {bit_in[ch], sr};

        // bit capture: shift the selected channel's bit in and count it
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sr  <= '0;
                cnt <= '0;
            end else if (sync) begin
                sr  <= '0;
                cnt <= '0;
            end else if (cap) begin
                sr  <= MSB_FIRST ? word[W-2:0] : word[W-1:1];
                cnt <= done ? '0 : cnt + 1'b1;
            end
        end

        // word state register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= COLLECT;
            end else begin
                state <= state_nxt;
            end
        end

        // next state: load on completion if the holding register is free or being consumed now
        always_comb begin
            state_nxt = state;
            load      = 1'b0;
            ovf_set   = 1'b0;
            case (state)
                COLLECT: begin
                    if (done) begin
                        load      = 1'b1;
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (done) begin
                        if (rdy[ch]) begin
                            load = 1'b1;
                        end else begin
                            ovf_set = 1'b1;
                        end
                    end else if (rdy[ch]) begin
                        state_nxt = COLLECT;
                    end
                end
                default: state_nxt = COLLECT;
            endcase
        end

        // holding register and sticky overflow; a new overflow beats clr_ovf
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                d_q   <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (load) begin
                    d_q <= word;
                end
                if (ovf_set) begin
                    ovf_q <= 1'b1;
                end else if (clr_ovf) begin
                    ovf_q <= 1'b0;
                end
            end
        end

        assign vout[ch] = (state == HOLD);
        assign dout[ch] = d_q;
        assign ovf[ch]  = ovf_q;
    end

    assign d0   = dout[0];
    assign d1   = dout[1];
    assign v0   = vout[0];
    assign v1   = vout[1];
    assign ovf0 = ovf[0];
    assign ovf1 = ovf[1];

endmodule
